alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the datapath width; it SHALL be a multiple of 4 and at least 8.
REQ-002 The block SHALL have parameter DECIMAL_EN, default 1; when 1, BCD mode SHALL be available for ADC and SBC.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- op  in  4  operation code
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- decimal  in  1  D flag; BCD mode for ADC/SBC
- c_load  in  1  carry write strobe (SEC/CLC)
- c_val  in  1  carry value written on c_load
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  registered result
- flag_c, flag_v, flag_z, flag_n  out  1 each  registered status flags

Function
REQ-005 The opcodes SHALL be: ADC=0, SBC=1, AND=2, ORA=3, EOR=4, ASL=5, LSR=6, ROL=7, ROR=8, CMP=9, PASS=10, INC=11, DEC=12; codes 13-15 SHALL behave as PASS with no flag update.
REQ-006 The carry input for every operation SHALL be the internal flag_c register; there SHALL be no external cin port.
REQ-007 The FSM SHALL have four states: IDLE, EXEC, BCD, DONE.
REQ-008 in_ready SHALL be 1 only in IDLE while rst_n=1.
REQ-009 A request SHALL be accepted when in_valid and in_ready are both 1; a, b, op and decimal SHALL be latched on that edge, and the FSM SHALL move to EXEC.
REQ-010 EXEC SHALL compute the binary result; it SHALL go to BCD when the op is ADC/SBC with latched decimal=1 and DECIMAL_EN=1, and to DONE otherwise.
REQ-011 BCD SHALL apply a per-nibble decimal adjust, then go to DONE.
REQ-012 result and the flags SHALL update on the edge that enters DONE; out_valid SHALL be 1 exactly in DONE.
REQ-013 Latency from acceptance edge to out_valid SHALL be 2 cycles for binary ops and 3 cycles for decimal ops.
REQ-014 In DONE, result and out_valid SHALL hold until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-015 ADC SHALL compute a+b+C, with C set to the carry out of the MSB and V = ~(a^b)[MSB] & (a^res)[MSB].
REQ-016 SBC SHALL compute a-b-~C; C SHALL be 1 when there is no borrow, and V = (a^b)[MSB] & (a^res)[MSB].
REQ-017 In decimal ADC, each nibble sum greater than 9 SHALL add 6 and carry into the next nibble; C SHALL be the carry out of the top nibble.
REQ-018 In decimal SBC, each nibble borrow SHALL subtract 6; C SHALL be the inverse of the top-nibble borrow.
REQ-019 In decimal mode, V SHALL be taken from the binary intermediate, and Z and N from the adjusted result.
REQ-020 AND, ORA, EOR, PASS, INC and DEC SHALL update only Z and N; C and V SHALL be unchanged.
REQ-021 For ASL and LSR, C SHALL take the bit shifted out.
REQ-022 For ROL and ROR, C SHALL take the bit shifted out and the old C SHALL be shifted in; V SHALL be unchanged.
REQ-023 CMP SHALL compute a-b without carry in, SHALL update C (no borrow), Z and N, and SHALL leave V unchanged.
REQ-024 INC and DEC SHALL operate on a and wrap modulo 2^WIDTH.
REQ-025 In all ops, Z SHALL be (res==0) and N SHALL be res[MSB].
REQ-026 c_load SHALL write c_val into flag_c only in IDLE; c_load SHALL be ignored in all other states.
REQ-027 If c_load and an accept occur on the same edge, the loaded value SHALL be the carry used by that operation.
REQ-028 Inputs other than out_ready and c_load SHALL be ignored while not in IDLE.

Reset
REQ-029 While rst_n=0 at a clock edge: the state SHALL become IDLE; result and all flags SHALL become 0; out_valid and in_ready SHALL be 0.
REQ-030 Reset asserted in EXEC, BCD or DONE SHALL abort the operation; no partial result or flag update SHALL be produced.

Structure
REQ-031 The op enum, the state enum and the opcode constants SHALL reside in the shared package alu_pkg.
REQ-032 The decimal adjust SHALL be a sub-module bcd_adjust (parameter WIDTH; inputs binary result, per-nibble carries/borrows, and subtract mode; outputs adjusted result and carry).

Verification (WIDTH=8)
REQ-033 ADC with a=0x50, b=0x50, C=0 -> result 0xA0, V=1, N=1, C=0, out_valid 2 cycles after accept.
REQ-034 Decimal ADC with a=0x99, b=0x01, C=0 -> result 0x00, C=1, Z=1, out_valid 3 cycles after accept.
REQ-035 Decimal SBC with a=0x10, b=0x01, C=1 -> result 0x09, C=1.
REQ-036 ROR with a=0x01 and C=1 preset via c_load -> result 0x80, C=1, N=1; the same edge as accept SHALL be tested.
REQ-037 Hold out_ready=0 for 5 cycles -> result stable, in_ready=0, a new in_valid is ignored.
REQ-038 Assert rst_n=0 during BCD -> next cycle IDLE, all outputs 0, no out_valid pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
//   op_t    : 4-bit operation codes presented on the op port
//   state_t : control FSM states
//   NIB_W   : width of one BCD digit
package alu_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [3:0] {
        OP_ADC  = 4'd0,
        OP_SBC  = 4'd1,
        OP_AND  = 4'd2,
        OP_ORA  = 4'd3,
        OP_EOR  = 4'd4,
        OP_ASL  = 4'd5,
        OP_LSR  = 4'd6,
        OP_ROL  = 4'd7,
        OP_ROR  = 4'd8,
        OP_CMP  = 4'd9,
        OP_PASS = 4'd10,
        OP_INC  = 4'd11,
        OP_DEC  = 4'd12
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_BCD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/bcd_adjust.sv
// Decimal adjust of a binary ADC/SBC result, one nibble at a time.
//   bin_res : binary sum/difference of the operands
//   nib_cy  : carry (add) or borrow (subtract) out of each nibble of the binary op
//   sub     : 1 = subtract (SBC), 0 = add (ADC)
//   adj_res : BCD-corrected result
//   cy_out  : decimal carry out of the top digit (for subtract: 1 = no borrow)
module bcd_adjust
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]       bin_res,
    input  logic [WIDTH/NIB_W-1:0] nib_cy,
    input  logic                   sub,
    output logic [WIDTH-1:0]       adj_res,
    output logic                   cy_out
);

    localparam int NIBS = WIDTH / NIB_W;

    // digit : true decimal digit sum/difference, 6-bit two's complement
    // extra : decimal carry/borrow from the digit below that the binary op did not see
    // dcy   : decimal carry/borrow out of the current digit
    logic [5:0] digit;
    logic       extra;
    logic       dcy;

    always_comb begin
        adj_res = '0;
        digit   = '0;
        extra   = 1'b0;
        dcy     = 1'b0;
        for (int i = 0; i < NIBS; i++) begin
            if (sub) begin
                // Rebuild the signed digit difference: a borrowed nibble is 16 too high.
                digit = {2'b00, bin_res[NIB_W*i +: NIB_W]}
                        - (nib_cy[i] ? 6'd16 : 6'd0) - {5'b0, extra};
                dcy   = digit[5];
                adj_res[NIB_W*i +: NIB_W] = dcy ? digit[3:0] - 4'd6 : digit[3:0];
            end else begin
                digit = {1'b0, nib_cy[i], bin_res[NIB_W*i +: NIB_W]} + {5'b0, extra};
                dcy   = (digit > 6'd9);
                adj_res[NIB_W*i +: NIB_W] = dcy ? digit[3:0] + 4'd6 : digit[3:0];
            end
            // A binary carry/borrow already propagated; only the decimal-only one is extra.
            extra = dcy & ~nib_cy[i];
        end
        cy_out = sub ? ~dcy : dcy;
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential 6502-style ALU with carry flag register and optional BCD mode.
// WIDTH must be a multiple of 4 and at least 8.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : request handshake (accepted only in IDLE)
//   op, a, b, decimal   : operation, operands, BCD enable for ADC/SBC
//   c_load / c_val      : direct write of the carry flag while IDLE
//   out_valid/out_ready : result handshake (out_valid high in DONE)
//   result, flag_c/v/z/n: registered result and status flags
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             decimal,
    input  logic             c_load,
    input  logic             c_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);

    localparam int NIBS = WIDTH / NIB_W;
    localparam int MSB  = WIDTH - 1;

    state_t state, state_nx;

    // Operands latched on accept
    logic [WIDTH-1:0] a_p0, b_p0;
    logic [3:0]       op_p0;
    logic             dec_p0;

    // Binary intermediate held for the decimal adjust cycle
    logic [WIDTH-1:0] bin_p1;
    logic [NIBS-1:0]  nib_p1;
    logic             v_p1;
    logic             sub_p1;

    // Execute-stage combinational results
    logic [WIDTH:0]   sum_w, dif_w, cmp_w;
    logic [WIDTH-1:0] x_res;
    logic             x_c, x_v, x_upd_c, x_upd_v, x_upd_zn;
    logic             x_sub;
    logic [NIBS-1:0]  x_nib;
    logic             go_bcd;

    logic [WIDTH-1:0] adj_res;
    logic             adj_cy;

    // Per-nibble carry (add) or borrow (subtract) chain of the binary op.
    function automatic logic [NIBS-1:0] nibble_carries(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin,
        input logic             sub
    );
        logic [NIBS-1:0] cy;
        logic [4:0]      t;
        logic            k;
        cy = '0;
        t  = '0;
        k  = cin;
        for (int i = 0; i < NIBS; i++) begin
            if (sub)
                t = {1'b0, x[NIB_W*i +: NIB_W]} - {1'b0, y[NIB_W*i +: NIB_W]} - {4'b0, k};
            else
                t = {1'b0, x[NIB_W*i +: NIB_W]} + {1'b0, y[NIB_W*i +: NIB_W]} + {4'b0, k};
            cy[i] = t[4];
            k     = t[4];
        end
        return cy;
    endfunction

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // ---- next-state logic ----
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nx = ST_EXEC;
            ST_EXEC: state_nx = go_bcd ? ST_BCD : ST_DONE;
            ST_BCD:  state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // ---- handshake outputs ----
    always_comb begin
        in_ready  = (state == ST_IDLE) && rst_n;
        out_valid = (state == ST_DONE) && rst_n;
    end

    // ---- accept: latch request ----
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid) begin
            a_p0   <= a;
            b_p0   <= b;
            op_p0  <= op;
            dec_p0 <= decimal;
        end
    end

    // ---- execute: binary result ----
    // Carry in is always the flag register; a c_load on the accept edge has already landed.
    assign sum_w = {1'b0, a_p0} + {1'b0, b_p0} + {{WIDTH{1'b0}}, flag_c};
    assign dif_w = {1'b0, a_p0} - {1'b0, b_p0} - {{WIDTH{1'b0}}, ~flag_c};
    assign cmp_w = {1'b0, a_p0} - {1'b0, b_p0};

    assign x_sub  = (op_p0 == OP_SBC);
    assign x_nib  = nibble_carries(a_p0, b_p0, x_sub ? ~flag_c : flag_c, x_sub);
    assign go_bcd = DECIMAL_EN && dec_p0 && (op_p0 == OP_ADC || op_p0 == OP_SBC);

    always_comb begin
        x_res    = a_p0;
        x_c      = flag_c;
        x_v      = flag_v;
        x_upd_c  = 1'b0;
        x_upd_v  = 1'b0;
        x_upd_zn = 1'b0;
        case (op_p0)
            OP_ADC: begin
                x_res    = sum_w[MSB:0];
                x_c      = sum_w[WIDTH];
                x_v      = ~(a_p0[MSB] ^ b_p0[MSB]) & (a_p0[MSB] ^ sum_w[MSB]);
                x_upd_c  = 1'b1;
                x_upd_v  = 1'b1;
                x_upd_zn = 1'b1;
            end
            OP_SBC: begin
                x_res    = dif_w[MSB:0];
                x_c      = ~dif_w[WIDTH];
                x_v      = (a_p0[MSB] ^ b_p0[MSB]) & (a_p0[MSB] ^ dif_w[MSB]);
                x_upd_c  = 1'b1;
                x_upd_v  = 1'b1;
                x_upd_zn = 1'b1;
            end
            OP_AND: begin
                x_res    = a_p0 & b_p0;
                x_upd_zn = 1'b1;
            end
            OP_ORA: begin
                x_res    = a_p0 | b_p0;
                x_upd_zn = 1'b1;
            end
            OP_EOR: begin
                x_res    = a_p0 ^ b_p0;
                x_upd_zn = 1'b1;
            end
            OP_ASL: begin
                x_res    = {a_p0[MSB-1:0], 1'b0};
                x_c      = a_p0[MSB];
                x_upd_c  = 1'b1;
                x_upd_zn = 1'b1;
            end
            OP_LSR: begin
                x_res    = {1'b0, a_p0[MSB:1]};
                x_c      = a_p0[0];
                x_upd_c  = 1'b1;
                x_upd_zn = 1'b1;
            end
            OP_ROL: begin
                x_res    = {a_p0[MSB-1:0], flag_c};
                x_c      = a_p0[MSB];
                x_upd_c  = 1'b1;
                x_upd_zn = 1'b1;
            end
            OP_ROR: begin
                x_res    = {flag_c, a_p0[MSB:1]};
                x_c      = a_p0[0];
                x_upd_c  = 1'b1;
                x_upd_zn = 1'b1;
            end
            OP_CMP: begin
                x_res    = cmp_w[MSB:0];
                x_c      = ~cmp_w[WIDTH];
                x_upd_c  = 1'b1;
                x_upd_zn = 1'b1;
            end
            OP_PASS: begin
                x_res    = a_p0;
                x_upd_zn = 1'b1;
            end
            OP_INC: begin
                x_res    = a_p0 + {{(WIDTH-1){1'b0}}, 1'b1};
                x_upd_zn = 1'b1;
            end
            OP_DEC: begin
                x_res    = a_p0 - {{(WIDTH-1){1'b0}}, 1'b1};
                x_upd_zn = 1'b1;
            end
            default: begin
                // Undefined codes pass a through and leave every flag alone.
                x_res = a_p0;
            end
        endcase
    end

    // ---- EXEC -> BCD: hold binary intermediate ----
    always_ff @(posedge clk) begin
        if (state == ST_EXEC && go_bcd) begin
            bin_p1 <= x_res;
            nib_p1 <= x_nib;
            v_p1   <= x_v;
            sub_p1 <= x_sub;
        end
    end

    bcd_adjust #(
        .WIDTH (WIDTH)
    ) u_bcd_adjust (
        .bin_res (bin_p1),
        .nib_cy  (nib_p1),
        .sub     (sub_p1),
        .adj_res (adj_res),
        .cy_out  (adj_cy)
    );

    // ---- result and flags: written only on the edge entering DONE ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (c_load) flag_c <= c_val;
                end
                ST_EXEC: begin
                    if (!go_bcd) begin
                        result <= x_res;
                        if (x_upd_c) flag_c <= x_c;
                        if (x_upd_v) flag_v <= x_v;
                        if (x_upd_zn) begin
                            flag_z <= (x_res == '0);
                            flag_n <= x_res[MSB];
                        end
                    end
                end
                ST_BCD: begin
                    // V comes from the binary intermediate, Z/N from the adjusted value.
                    result <= adj_res;
                    flag_c <= adj_cy;
                    flag_v <= v_p1;
                    flag_z <= (adj_res == '0);
                    flag_n <= adj_res[MSB];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       decimal;
    logic       c_load, c_val;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_c, flag_v, flag_z, flag_n;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .decimal   (decimal),
        .c_load    (c_load),
        .c_val     (c_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preset_c(input logic v);
        c_load = 1'b1;
        c_val  = v;
        tick();
        c_load = 1'b0;
    endtask

    // Issue one request, measure edges from accept to out_valid, check, then return to IDLE.
    // flags are packed {C,V,Z,N}.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [7:0] va,
                         input logic [7:0] vb, input logic dec, input logic chk_res,
                         input logic [7:0] exp_res, input logic [3:0] exp_flags,
                         input int exp_lat);
        int lat;
        op       = o;
        a        = va;
        b        = vb;
        decimal  = dec;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        c_load   = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        if (chk_res) check({tag, " result"}, result, exp_res);
        check({tag, " flags"}, {flag_c, flag_v, flag_z, flag_n}, exp_flags);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'd0;
        a         = 8'h00;
        b         = 8'h00;
        decimal   = 1'b0;
        c_load    = 1'b0;
        c_val     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check("rst result", result, 8'h00);
        check("rst flags", {flag_c, flag_v, flag_z, flag_n}, 4'b0000);
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        check("idle in_ready", in_ready, 1'b1);

        // Binary ADC overflow: 0x50+0x50, C=0
        do_op("adc_bin", OP_ADC, 8'h50, 8'h50, 1'b0, 1'b1, 8'hA0, 4'b0101, 2);
        // Decimal ADC 99+01, C=0
        do_op("adc_dec", OP_ADC, 8'h99, 8'h01, 1'b1, 1'b1, 8'h00, 4'b1010, 3);
        // Decimal SBC 10-01, C=1
        do_op("sbc_dec", OP_SBC, 8'h10, 8'h01, 1'b1, 1'b1, 8'h09, 4'b1000, 3);

        // ROR with C loaded on the accept edge
        preset_c(1'b0);
        check("clc", flag_c, 1'b0);
        c_load = 1'b1;
        c_val  = 1'b1;
        do_op("ror_cload", OP_ROR, 8'h01, 8'h00, 1'b0, 1'b1, 8'h80, 4'b1001, 2);

        do_op("and", OP_AND, 8'hF0, 8'h0F, 1'b0, 1'b1, 8'h00, 4'b1010, 2);
        do_op("ora", OP_ORA, 8'h80, 8'h01, 1'b0, 1'b1, 8'h81, 4'b1001, 2);
        do_op("eor", OP_EOR, 8'hFF, 8'h0F, 1'b0, 1'b1, 8'hF0, 4'b1001, 2);
        preset_c(1'b0);
        do_op("asl", OP_ASL, 8'h81, 8'h00, 1'b0, 1'b1, 8'h02, 4'b1000, 2);
        do_op("lsr", OP_LSR, 8'h01, 8'h00, 1'b0, 1'b1, 8'h00, 4'b1010, 2);
        do_op("rol", OP_ROL, 8'h80, 8'h00, 1'b0, 1'b1, 8'h01, 4'b1000, 2);
        do_op("sbc_bin", OP_SBC, 8'h50, 8'hB0, 1'b0, 1'b1, 8'hA0, 4'b0101, 2);
        do_op("cmp_eq", OP_CMP, 8'h40, 8'h40, 1'b0, 1'b0, 8'h00, 4'b1110, 2);
        do_op("inc_wrap", OP_INC, 8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 4'b1110, 2);
        do_op("dec_wrap", OP_DEC, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 4'b1101, 2);
        do_op("pass", OP_PASS, 8'h7E, 8'h00, 1'b0, 1'b1, 8'h7E, 4'b1100, 2);
        do_op("op13", 4'd13, 8'h33, 8'h00, 1'b0, 1'b1, 8'h33, 4'b1100, 2);
        preset_c(1'b0);
        do_op("adc_dec_chain", OP_ADC, 8'h58, 8'h46, 1'b1, 1'b1, 8'h04, 4'b1100, 3);

        // Hold result with out_ready=0; new requests and c_load are ignored
        preset_c(1'b0);
        out_ready = 1'b0;
        do_op("hold_adc", OP_ADC, 8'h01, 8'h02, 1'b0, 1'b1, 8'h03, 4'b0000, 2);
        // do_op ticked once while out_ready=0, still in DONE
        in_valid = 1'b1;
        op       = OP_PASS;
        a        = 8'hEE;
        c_load   = 1'b1;
        c_val    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold result", result, 8'h03);
            check("hold out_valid", out_valid, 1'b1);
            check("hold in_ready", in_ready, 1'b0);
        end
        check("hold c_load ignored", flag_c, 1'b0);
        in_valid  = 1'b0;
        c_load    = 1'b0;
        out_ready = 1'b1;
        tick();
        check("release out_valid", out_valid, 1'b0);
        check("release in_ready", in_ready, 1'b1);
        tick();
        tick();
        check("no phantom op", out_valid, 1'b0);
        check("no phantom result", result, 8'h03);

        // Reset during BCD aborts without producing a result
        preset_c(1'b1);
        op       = OP_ADC;
        a        = 8'h12;
        b        = 8'h34;
        decimal  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        check("abort in_ready low", in_ready, 1'b0);
        tick();
        check("abort result", result, 8'h00);
        check("abort flags", {flag_c, flag_v, flag_z, flag_n}, 4'b0000);
        check("abort out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post abort out_valid", out_valid, 1'b0);
        end
        check("post abort in_ready", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
